// File: rtl/commit_store_buffer_pkg.sv
// Shared definitions for the committed-store buffer.
// Holds the default depth, the store-size funct3 encodings and the drain FSM states.
package commit_store_buffer_pkg;

  localparam int unsigned SbDepthDefault = 8;

  // Store size encodings carried in the ROB funct3 field
  localparam logic [2:0] Funct3Sb = 3'b000;
  localparam logic [2:0] Funct3Sh = 3'b001;
  localparam logic [2:0] Funct3Sw = 3'b010;

  typedef enum logic {
    DrainIdle,
    DrainReq
  } drain_state_e;

endpackage

// File: rtl/sb_lane_align.sv
// Store size/lane alignment.
// Maps a store's funct3 and low address bits to byte enables, and replicates the store data so
// that every enabled lane carries the correct byte.
// Ports:
//   i_funct3   store size (SB/SH/SW)
//   i_addr_lo  byte address bits [1:0]
//   i_data     raw store data from the ROB
//   o_be       byte enables, lane 0 = bits [7:0]
//   o_data     lane-aligned write data
//   o_legal    funct3 is one of SB/SH/SW
module sb_lane_align
  import commit_store_buffer_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_data,
  output logic        o_legal
);

  always_comb begin
    o_be    = 4'b0000;
    o_data  = '0;
    o_legal = 1'b0;
    case (i_funct3)
      Funct3Sb: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_data  = {4{i_data[7:0]}};
        o_legal = 1'b1;
      end
      Funct3Sh: begin
        // addr[0] is ignored: halfwords are forced onto a halfword lane pair
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_data  = {2{i_data[15:0]}};
        o_legal = 1'b1;
      end
      Funct3Sw: begin
        o_be    = 4'b1111;
        o_data  = i_data;
        o_legal = 1'b1;
      end
      default: begin
        o_be    = 4'b0000;
        o_data  = '0;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/commit_store_buffer.sv
// Committed store buffer.
// Retired stores from the ROB are queued in FIFO order and drained one at a time to data memory
// through a request/acknowledge handshake. Loads probe the buffer combinationally: a youngest
// full-word match forwards its data, any other match reports a conflict so the load waits.
// Entries are architecturally committed and are never flushed except by reset.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   commit_valid/addr/data/funct3  committed store from the ROB
//   sb_full, sb_empty          occupancy flags from the registered count
//   mem_req/addr/wdata/be      write request to data memory, held stable until mem_ack
//   mem_ack                    memory accepted the current request
//   ld_addr                    load address to probe
//   ld_fwd_hit, ld_fwd_data    full-word forwarding result
//   ld_conflict                partial match, load must wait
//   err_sticky                 overflow or illegal funct3 seen since reset
module commit_store_buffer
  import commit_store_buffer_pkg::*;
#(
  parameter int unsigned SB_DEPTH = SbDepthDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_addr,
  input  logic [31:0] commit_data,
  input  logic [2:0]  commit_funct3,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_fwd_hit,
  output logic [31:0] ld_fwd_data,
  output logic        ld_conflict,
  output logic        err_sticky
);

  localparam int unsigned PtrW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(SB_DEPTH + 1);

  logic [29:0]     r_word [SB_DEPTH];
  logic [31:0]     r_data [SB_DEPTH];
  logic [3:0]      r_be   [SB_DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;
  logic            r_err;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;
  logic [3:0]      r_mem_be;
  drain_state_e    r_state;
  drain_state_e    w_state_next;

  logic [3:0]      w_al_be;
  logic [31:0]     w_al_data;
  logic            w_al_legal;
  logic            w_push;
  logic            w_pop;
  logic [PtrW-1:0] w_fwd_idx;
  logic            w_fwd_hit;
  logic            w_fwd_conf;
  logic [31:0]     w_fwd_data;
  logic            w_unused_ld_lo;

  sb_lane_align u_lane_align (
    .i_funct3  (commit_funct3),
    .i_addr_lo (commit_addr[1:0]),
    .i_data    (commit_data),
    .o_be      (w_al_be),
    .o_data    (w_al_data),
    .o_legal   (w_al_legal)
  );

  // Full is taken from the registered count, so a pop in the same cycle cannot admit a store
  assign sb_full  = (r_count == CntW'(SB_DEPTH));
  assign sb_empty = (r_count == '0);
  assign w_push   = commit_valid & ~sb_full & w_al_legal;
  assign w_pop    = (r_state == DrainReq) & mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        r_word[i] <= '0;
        r_data[i] <= '0;
        r_be[i]   <= '0;
      end
    end else begin
      if (w_push) begin
        r_word[r_tail] <= commit_addr[31:2];
        r_data[r_tail] <= w_al_data;
        r_be[r_tail]   <= w_al_be;
        r_tail         <= r_tail + PtrW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (commit_valid && (sb_full || !w_al_legal)) begin
        r_err <= 1'b1;
      end
      // Capture the head entry on entry to REQ; it then stays frozen until acknowledged
      if (r_state == DrainIdle && r_count != '0) begin
        r_mem_addr  <= {r_word[r_head], 2'b00};
        r_mem_wdata <= r_data[r_head];
        r_mem_be    <= r_be[r_head];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DrainIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      DrainIdle: if (r_count != '0) w_state_next = DrainReq;
      DrainReq:  if (mem_ack)       w_state_next = DrainIdle;
      default:   w_state_next = DrainIdle;
    endcase
  end

  assign mem_req   = (r_state == DrainReq);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign err_sticky = r_err;

  // Walk entries oldest to youngest so the last match seen is the youngest one
  always_comb begin
    w_fwd_idx  = '0;
    w_fwd_hit  = 1'b0;
    w_fwd_conf = 1'b0;
    w_fwd_data = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      w_fwd_idx = r_head + PtrW'(k);
      if ((CntW'(k) < r_count) && (r_word[w_fwd_idx] == ld_addr[31:2])) begin
        w_fwd_hit  = (r_be[w_fwd_idx] == 4'b1111);
        w_fwd_conf = (r_be[w_fwd_idx] != 4'b1111);
        w_fwd_data = r_data[w_fwd_idx];
      end
    end
  end

  assign ld_fwd_hit     = w_fwd_hit;
  assign ld_conflict    = w_fwd_conf;
  assign ld_fwd_data    = w_fwd_data;
  assign w_unused_ld_lo = ^ld_addr[1:0];

endmodule

// File: tb/tb_commit_store_buffer.sv
// Bench for commit_store_buffer: a per-cycle vector table plus directed sequences for the
// overflow/drain and reset-during-request cases. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, i.e. before the next rising edge.
module tb_commit_store_buffer;
  import commit_store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [2:0]  commit_funct3;
  logic        sb_full;
  logic        sb_empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        ld_conflict;
  logic        err_sticky;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commit_store_buffer #(.SB_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .commit_valid  (commit_valid),
    .commit_addr   (commit_addr),
    .commit_data   (commit_data),
    .commit_funct3 (commit_funct3),
    .sb_full       (sb_full),
    .sb_empty      (sb_empty),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_ack       (mem_ack),
    .ld_addr       (ld_addr),
    .ld_fwd_hit    (ld_fwd_hit),
    .ld_fwd_data   (ld_fwd_data),
    .ld_conflict   (ld_conflict),
    .err_sticky    (err_sticky)
  );

  typedef struct {
    string       name;
    logic        cv;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [2:0]  f3;
    logic        ack;
    logic [31:0] la;
    logic        chk_mem;
    logic        e_full;
    logic        e_empty;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_hit;
    logic [31:0] e_fdata;
    logic        e_conf;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(string nm, logic cv, logic [31:0] ca, logic [31:0] cd,
                             logic [2:0] f3, logic ack, logic [31:0] la, logic chk_mem,
                             logic e_full, logic e_empty, logic e_req, logic [31:0] e_addr,
                             logic [31:0] e_wdata, logic [3:0] e_be, logic e_hit,
                             logic [31:0] e_fdata, logic e_conf, logic e_err);
    vec_t t;
    t.name = nm;       t.cv = cv;           t.ca = ca;         t.cd = cd;
    t.f3 = f3;         t.ack = ack;         t.la = la;         t.chk_mem = chk_mem;
    t.e_full = e_full; t.e_empty = e_empty; t.e_req = e_req;   t.e_addr = e_addr;
    t.e_wdata = e_wdata; t.e_be = e_be;     t.e_hit = e_hit;   t.e_fdata = e_fdata;
    t.e_conf = e_conf; t.e_err = e_err;
    return t;
  endfunction

  task automatic drive(input logic r, input logic cv, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f, input logic ak,
                       input logic [31:0] la);
    @(negedge clk);
    rst           = r;
    commit_valid  = cv;
    commit_addr   = a;
    commit_data   = d;
    commit_funct3 = f;
    mem_ack       = ak;
    ld_addr       = la;
    #1;
  endtask

  task automatic idle(input logic [31:0] la);
    drive(1'b0, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b0, la);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bounded wait for a drain request; an expired bound shows up as a failed check
  task automatic wait_req(input string nm);
    for (int i = 0; i < 6; i++) begin
      idle(32'h0);
      if (mem_req === 1'b1) break;
    end
    check(nm, 32'(mem_req), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    vec_t t;

    //        name                    cv  addr      data          f3        ak  ld_addr   cm
    //        full empty req  mem_addr  mem_wdata     be     hit fwd_data      conf err
    vecs.push_back(v("reset_sw_push",      1, 32'h100, 32'hDEADBEEF, Funct3Sw, 0, 32'h100, 1,
                     0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0));
    vecs.push_back(v("sw_fwd_before_drain", 0, 32'h0, 32'h0,        Funct3Sw, 0, 32'h100, 0,
                     0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'hDEADBEEF, 0, 0));
    vecs.push_back(v("sw_req_ack",         0, 32'h0,   32'h0,        Funct3Sw, 1, 32'h104, 1,
                     0, 0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 0));
    vecs.push_back(v("sb_push_idle_ack",   1, 32'h203, 32'h000000AB, Funct3Sb, 1, 32'h200, 0,
                     0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0));
    vecs.push_back(v("sb_conflict_idle",   0, 32'h0,   32'h0,        Funct3Sw, 1, 32'h200, 0,
                     0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        1, 0));
    vecs.push_back(v("sb_req",             0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h200, 1,
                     0, 0, 1, 32'h200, 32'hABABABAB, 4'h8, 0, 32'h0,        1, 0));
    vecs.push_back(v("sb_req_hold",        0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h203, 1,
                     0, 0, 1, 32'h200, 32'hABABABAB, 4'h8, 0, 32'h0,        1, 0));
    vecs.push_back(v("sb_ack",             0, 32'h0,   32'h0,        Funct3Sw, 1, 32'h204, 1,
                     0, 0, 1, 32'h200, 32'hABABABAB, 4'h8, 0, 32'h0,        0, 0));
    vecs.push_back(v("sw40_a",             1, 32'h40,  32'h11111111, Funct3Sw, 0, 32'h40,  0,
                     0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0));
    vecs.push_back(v("sw40_b",             1, 32'h40,  32'h22222222, Funct3Sw, 0, 32'h42,  0,
                     0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h11111111, 0, 0));
    vecs.push_back(v("sh_push_youngest",   1, 32'h47,  32'h0000BEEF, Funct3Sh, 0, 32'h42,  1,
                     0, 0, 1, 32'h40,  32'h11111111, 4'hF, 1, 32'h22222222, 0, 0));
    vecs.push_back(v("push_pop_cnt3",      1, 32'h45,  32'h0000005A, Funct3Sb, 1, 32'h44,  1,
                     0, 0, 1, 32'h40,  32'h11111111, 4'hF, 0, 32'h0,        1, 0));
    vecs.push_back(v("after_push_pop",     0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h40,  0,
                     0, 0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h22222222, 0, 0));
    vecs.push_back(v("drain_sw40b",        0, 32'h0,   32'h0,        Funct3Sw, 1, 32'h44,  1,
                     0, 0, 1, 32'h40,  32'h22222222, 4'hF, 0, 32'h0,        1, 0));
    vecs.push_back(v("idle_gap",           0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h0,   0,
                     0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0));
    vecs.push_back(v("drain_sh",           0, 32'h0,   32'h0,        Funct3Sw, 1, 32'h44,  1,
                     0, 0, 1, 32'h44,  32'hBEEFBEEF, 4'hC, 0, 32'h0,        1, 0));
    vecs.push_back(v("idle_gap2",          0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h0,   0,
                     0, 0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0));
    vecs.push_back(v("drain_sb",           0, 32'h0,   32'h0,        Funct3Sw, 1, 32'h44,  1,
                     0, 0, 1, 32'h44,  32'h5A5A5A5A, 4'h2, 0, 32'h0,        1, 0));
    vecs.push_back(v("illegal_f3",         1, 32'h80,  32'h12345678, 3'b011,   0, 32'h80,  0,
                     0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 0));
    vecs.push_back(v("err_set",            0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h80,  0,
                     0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 1));
    vecs.push_back(v("no_drain_illegal",   0, 32'h0,   32'h0,        Funct3Sw, 0, 32'h0,   0,
                     0, 1, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0, 1));

    drive(1'b1, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      t = vecs[i];
      drive(1'b0, t.cv, t.ca, t.cd, t.f3, t.ack, t.la);
      ok = (sb_full === t.e_full) && (sb_empty === t.e_empty) && (mem_req === t.e_req) &&
           (ld_fwd_hit === t.e_hit) && (ld_conflict === t.e_conf) &&
           (err_sticky === t.e_err);
      if (t.chk_mem) begin
        ok = ok && (mem_addr === t.e_addr) && (mem_wdata === t.e_wdata) &&
             (mem_be === t.e_be);
      end
      if (t.e_hit) ok = ok && (ld_fwd_data === t.e_fdata);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s: got full=%b empty=%b req=%b addr=%h wdata=%h be=%b hit=%b fwd=%h conf=%b err=%b; expected full=%b empty=%b req=%b addr=%h wdata=%h be=%b hit=%b fwd=%h conf=%b err=%b",
                 t.name, sb_full, sb_empty, mem_req, mem_addr, mem_wdata, mem_be, ld_fwd_hit,
                 ld_fwd_data, ld_conflict, err_sticky, t.e_full, t.e_empty, t.e_req, t.e_addr,
                 t.e_wdata, t.e_be, t.e_hit, t.e_fdata, t.e_conf, t.e_err);
      end
    end

    // Overflow: nine stores with no acks, the ninth is dropped; then drain all eight in order
    drive(1'b1, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), Funct3Sw, 1'b0, 32'h0);
      if (i == 0) begin
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_err_clear", 32'(err_sticky), 32'h0);
        check("rst_empty", 32'(sb_empty), 32'h1);
      end
      check($sformatf("full_before_push%0d", i), 32'(sb_full), 32'(i == 8));
    end
    idle(32'h1020);
    check("ovf_err", 32'(err_sticky), 32'h1);
    check("ovf_full", 32'(sb_full), 32'h1);
    check("ovf_dropped_no_hit", 32'(ld_fwd_hit), 32'h0);
    idle(32'h101C);
    check("full_fwd_hit", 32'(ld_fwd_hit), 32'h1);
    check("full_fwd_data", ld_fwd_data, 32'hA7);
    for (int i = 0; i < 8; i++) begin
      wait_req($sformatf("drain%0d_req", i));
      check($sformatf("drain%0d_addr", i), mem_addr, 32'h1000 + 32'(4 * i));
      check($sformatf("drain%0d_wdata", i), mem_wdata, 32'hA0 + 32'(i));
      drive(1'b0, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b1, 32'h0);
    end
    idle(32'h0);
    check("drained_empty", 32'(sb_empty), 32'h1);
    check("drained_not_full", 32'(sb_full), 32'h0);

    // Reset while a request is outstanding drops it; a late ack must not pop anything
    drive(1'b0, 1'b1, 32'h300, 32'h33, Funct3Sw, 1'b0, 32'h0);
    wait_req("pre_rst_req");
    check("pre_rst_addr", mem_addr, 32'h300);
    drive(1'b1, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b1, 32'h300);
    check("rst_req_drop", 32'(mem_req), 32'h0);
    check("rst_req_empty", 32'(sb_empty), 32'h1);
    check("rst_req_addr", mem_addr, 32'h0);
    check("rst_req_no_fwd", 32'(ld_fwd_hit), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b1, 32'h0);
    check("late_ack_no_req", 32'(mem_req), 32'h0);
    drive(1'b0, 1'b1, 32'h304, 32'h44, Funct3Sw, 1'b0, 32'h0);
    check("late_ack_empty", 32'(sb_empty), 32'h1);
    wait_req("post_rst_req");
    check("post_rst_addr", mem_addr, 32'h304);
    check("post_rst_wdata", mem_wdata, 32'h44);
    check("post_rst_be", 32'(mem_be), 32'hF);
    drive(1'b0, 1'b0, 32'h0, 32'h0, Funct3Sw, 1'b1, 32'h0);
    idle(32'h0);
    check("post_rst_empty", 32'(sb_empty), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
